// File: rtl/periph_interco_pkg.sv
// Shared types and constants for the peripheral interconnect response path.
// Optional feature macro used by the top: PERIPH_RESP_BYPASS_EN.
package periph_interco_pkg;

    localparam int RESP_DATA_WIDTH           = 32;
    localparam int PERIPH_RESP_DEPTH_DEFAULT = 4;

    typedef struct packed {
        logic [RESP_DATA_WIDTH-1:0] rdata;
        logic                       opc;
    } resp_t;

    // Pointer width that stays legal for a single-entry FIFO.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/periph_resp_fifo.sv
// Response storage FIFO. Pointers wrap modulo DEPTH, so non-power-of-2
// depths are supported. The head reads as zero while the FIFO is empty.
module periph_resp_fifo
    import periph_interco_pkg::*;
#(
    parameter int WIDTH = RESP_DATA_WIDTH + 1,
    parameter int DEPTH = PERIPH_RESP_DEPTH_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = ptr_width(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign rdata   = empty ? '0 : mem[rd_ptr];

    // Storage write; entries need no reset since the head is masked when empty.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy tracking; simultaneous push and pop keeps count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wrap_inc(wr_ptr);
            end
            if (pop_ok) begin
                rd_ptr <= wrap_inc(rd_ptr);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/periph_pe_resp_buffer.sv
// PE-side response buffer with credit-based request throttling.
// Credits cover both requests in flight and responses already buffered, so a
// granted request always has a FIFO slot waiting for its response.
// Optional feature: define PERIPH_RESP_BYPASS_EN to let a response reach the
// PE combinationally when the FIFO is empty and the PE is ready.
module periph_pe_resp_buffer
    import periph_interco_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = PERIPH_RESP_DEPTH_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       pe_req_i,
    input  logic [ADDR_WIDTH-1:0]      pe_add_i,
    output logic                       pe_gnt_o,
    output logic                       pe_r_valid_o,
    output logic [DATA_WIDTH-1:0]      pe_r_rdata_o,
    output logic                       pe_r_opc_o,
    input  logic                       pe_r_ready_i,
    output logic                       data_req_o,
    output logic [ADDR_WIDTH-1:0]      data_add_o,
    input  logic                       data_gnt_i,
    input  logic                       data_r_valid_i,
    input  logic [DATA_WIDTH-1:0]      data_r_rdata_i,
    input  logic                       data_r_opc_i,
    output logic [$clog2(DEPTH+1)-1:0] credit_o,
    output logic                       err_o
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [CW-1:0]       outstanding;
    logic [CW-1:0]       fifo_count;
    logic                fifo_full;
    logic                fifo_empty;
    logic [DATA_WIDTH:0] fifo_head;
    logic                accept;
    logic                resp_ok;
    logic                drop;
    logic                bypass;
    logic                push;
    logic                pop;

    assign credit_o   = CW'(DEPTH) - outstanding - fifo_count;
    assign data_req_o = rst_n & pe_req_i & (credit_o != '0);
    assign pe_gnt_o   = data_gnt_i & data_req_o;
    assign data_add_o = pe_add_i;

    assign accept  = data_req_o & data_gnt_i;
    assign resp_ok = data_r_valid_i & (outstanding != '0);
    assign drop    = data_r_valid_i & (outstanding == '0);

`ifdef PERIPH_RESP_BYPASS_EN
    assign bypass = rst_n & resp_ok & fifo_empty & pe_r_ready_i;
`else
    assign bypass = 1'b0;
`endif

    // The full term never blocks a legal push (credits prevent overflow);
    // it only keeps the FIFO safe against an upstream protocol violation.
    assign push = resp_ok & ~bypass & (~fifo_full | pop);
    assign pop  = ~fifo_empty & pe_r_ready_i;

    assign pe_r_valid_o = ~fifo_empty | bypass;
    assign pe_r_rdata_o = bypass ? data_r_rdata_i : fifo_head[DATA_WIDTH:1];
    assign pe_r_opc_o   = bypass ? data_r_opc_i   : fifo_head[0];

    periph_resp_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata ({data_r_rdata_i, data_r_opc_i}),
        .pop   (pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Requests in flight: grant adds one, a legal response (pushed or
    // bypassed) retires one; both together cancel out.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            outstanding <= '0;
        end else begin
            case ({accept, resp_ok})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Sticky flag for responses that arrive with nothing outstanding.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_o <= 1'b0;
        end else if (drop) begin
            err_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_periph_pe_resp_buffer.sv
// Directed, table-driven bench for periph_pe_resp_buffer (DEPTH=4).
// Honours PERIPH_RESP_BYPASS_EN when choosing expected response timing.
module tb_periph_pe_resp_buffer;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int CW = 3;

`ifdef PERIPH_RESP_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          pe_req_i;
    logic [AW-1:0] pe_add_i;
    logic          pe_gnt_o;
    logic          pe_r_valid_o;
    logic [DW-1:0] pe_r_rdata_o;
    logic          pe_r_opc_o;
    logic          pe_r_ready_i;
    logic          data_req_o;
    logic [AW-1:0] data_add_o;
    logic          data_gnt_i;
    logic          data_r_valid_i;
    logic [DW-1:0] data_r_rdata_i;
    logic          data_r_opc_i;
    logic [CW-1:0] credit_o;
    logic          err_o;

    int n_checks = 0;
    int n_fail   = 0;
    int n_grants = 0;

    periph_pe_resp_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pe_req_i       (pe_req_i),
        .pe_add_i       (pe_add_i),
        .pe_gnt_o       (pe_gnt_o),
        .pe_r_valid_o   (pe_r_valid_o),
        .pe_r_rdata_o   (pe_r_rdata_o),
        .pe_r_opc_o     (pe_r_opc_o),
        .pe_r_ready_i   (pe_r_ready_i),
        .data_req_o     (data_req_o),
        .data_add_o     (data_add_o),
        .data_gnt_i     (data_gnt_i),
        .data_r_valid_i (data_r_valid_i),
        .data_r_rdata_i (data_r_rdata_i),
        .data_r_opc_i   (data_r_opc_i),
        .credit_o       (credit_o),
        .err_o          (err_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        req;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        ropc;
        logic        ready;
        logic        x_req;
        logic        x_gnt;
        logic        x_valid;
        logic [31:0] x_rdata;
        logic        x_opc;
        logic [2:0]  x_credit;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic req, input logic gnt, input logic rv,
                         input logic [31:0] rdata, input logic ropc, input logic ready);
        pe_req_i       = req;
        data_gnt_i     = gnt;
        data_r_valid_i = rv;
        data_r_rdata_i = rdata;
        data_r_opc_i   = ropc;
        pe_r_ready_i   = ready;
    endtask

    // Inputs change just after a falling edge; checks follow 1 time unit later.
    task automatic step_drive(input logic req, input logic gnt, input logic rv,
                              input logic [31:0] rdata, input logic ropc, input logic ready);
        @(negedge clk);
        drive(req, gnt, rv, rdata, ropc, ready);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive(0, 0, 0, 32'h0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n    = 1'b0;
        pe_add_i = 32'h1234_5678;
        drive(0, 0, 0, 32'h0, 0, 0);

        //            req gnt rv  rdata         opc rdy  xreq xgnt xval xrdata        xopc xcred
        vecs[0]  = '{1, 1, 0, 32'h0,       0, 0,  1, 1, 0, 32'h0,       0, 3'd4};
        vecs[1]  = '{1, 1, 0, 32'h0,       0, 0,  1, 1, 0, 32'h0,       0, 3'd3};
        vecs[2]  = '{1, 1, 0, 32'h0,       0, 0,  1, 1, 0, 32'h0,       0, 3'd2};
        vecs[3]  = '{1, 1, 0, 32'h0,       0, 0,  1, 1, 0, 32'h0,       0, 3'd1};
        vecs[4]  = '{1, 1, 0, 32'h0,       0, 0,  0, 0, 0, 32'h0,       0, 3'd0};
        vecs[5]  = '{1, 1, 0, 32'h0,       0, 0,  0, 0, 0, 32'h0,       0, 3'd0};
        vecs[6]  = '{0, 0, 1, 32'hA0,      0, 0,  0, 0, 0, 32'h0,       0, 3'd0};
        vecs[7]  = '{0, 0, 1, 32'hA1,      1, 0,  0, 0, 1, 32'hA0,      0, 3'd0};
        vecs[8]  = '{0, 0, 1, 32'hA2,      0, 0,  0, 0, 1, 32'hA0,      0, 3'd0};
        vecs[9]  = '{0, 0, 1, 32'hA3,      0, 0,  0, 0, 1, 32'hA0,      0, 3'd0};
        vecs[10] = '{1, 1, 0, 32'h0,       0, 0,  0, 0, 1, 32'hA0,      0, 3'd0};
        vecs[11] = '{0, 0, 0, 32'h0,       0, 1,  0, 0, 1, 32'hA0,      0, 3'd0};
        vecs[12] = '{0, 0, 0, 32'h0,       0, 1,  0, 0, 1, 32'hA1,      1, 3'd1};
        vecs[13] = '{0, 0, 0, 32'h0,       0, 1,  0, 0, 1, 32'hA2,      0, 3'd2};
        vecs[14] = '{0, 0, 0, 32'h0,       0, 1,  0, 0, 1, 32'hA3,      0, 3'd3};
        vecs[15] = '{0, 0, 0, 32'h0,       0, 1,  0, 0, 0, 32'h0,       0, 3'd4};
        vecs[16] = '{1, 1, 0, 32'h0,       0, 0,  1, 1, 0, 32'h0,       0, 3'd4};
        vecs[17] = '{1, 1, 0, 32'h0,       0, 0,  1, 1, 0, 32'h0,       0, 3'd3};
        vecs[18] = '{1, 1, 1, 32'hB0,      1, 0,  1, 1, 0, 32'h0,       0, 3'd2};
        vecs[19] = '{0, 0, 0, 32'h0,       0, 0,  0, 0, 1, 32'hB0,      1, 3'd1};
        vecs[20] = '{0, 0, 0, 32'h0,       0, 1,  0, 0, 1, 32'hB0,      1, 3'd1};
        vecs[21] = '{0, 0, 0, 32'h0,       0, 0,  0, 0, 0, 32'h0,       0, 3'd2};

        // Reset state
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_valid",  {31'd0, pe_r_valid_o}, 32'd0);
        check("reset_rdata",  pe_r_rdata_o, 32'h0);
        check("reset_opc",    {31'd0, pe_r_opc_o}, 32'd0);
        check("reset_credit", {29'd0, credit_o}, 32'd4);
        check("reset_err",    {31'd0, err_o}, 32'd0);
        check("addr_pass",    data_add_o, 32'h1234_5678);

        // Credit exhaustion, in-order drain, same-cycle grant plus response
        for (int i = 0; i < NV; i++) begin
            if (i != 0) @(negedge clk);
            drive(vecs[i].req, vecs[i].gnt, vecs[i].rv, vecs[i].rdata, vecs[i].ropc, vecs[i].ready);
            #1;
            if (i < 6 && pe_gnt_o) n_grants++;
            check($sformatf("v%0d_data_req", i), {31'd0, data_req_o},   {31'd0, vecs[i].x_req});
            check($sformatf("v%0d_pe_gnt", i),   {31'd0, pe_gnt_o},     {31'd0, vecs[i].x_gnt});
            check($sformatf("v%0d_r_valid", i),  {31'd0, pe_r_valid_o}, {31'd0, vecs[i].x_valid});
            check($sformatf("v%0d_rdata", i),    pe_r_rdata_o,          vecs[i].x_rdata);
            check($sformatf("v%0d_opc", i),      {31'd0, pe_r_opc_o},   {31'd0, vecs[i].x_opc});
            check($sformatf("v%0d_credit", i),   {29'd0, credit_o},     {29'd0, vecs[i].x_credit});
            check($sformatf("v%0d_err", i),      {31'd0, err_o},        32'd0);
        end
        check("grant_count", n_grants, 4);

        // Reset mid-transaction: 2 outstanding, 2 buffered
        do_reset();
        for (int i = 0; i < 4; i++) step_drive(1, 1, 0, 32'h0, 0, 0);
        step_drive(0, 0, 1, 32'hC0, 0, 0);
        step_drive(0, 0, 1, 32'hC1, 0, 0);
        step_drive(0, 0, 0, 32'h0, 0, 0);
        check("pre_rst_credit", {29'd0, credit_o}, 32'd0);
        check("pre_rst_valid",  {31'd0, pe_r_valid_o}, 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        drive(1, 1, 0, 32'h0, 0, 0);
        #1;
        check("in_rst_data_req", {31'd0, data_req_o}, 32'd0);
        check("in_rst_pe_gnt",   {31'd0, pe_gnt_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 0, 32'h0, 0, 0);
        #1;
        check("post_rst_valid",  {31'd0, pe_r_valid_o}, 32'd0);
        check("post_rst_rdata",  pe_r_rdata_o, 32'h0);
        check("post_rst_opc",    {31'd0, pe_r_opc_o}, 32'd0);
        check("post_rst_credit", {29'd0, credit_o}, 32'd4);

        // Late response after reset is dropped and flags the error
        step_drive(0, 0, 1, 32'h77, 1, 1);
        check("drop_valid_same", {31'd0, pe_r_valid_o}, 32'd0);
        step_drive(0, 0, 0, 32'h0, 0, 1);
        check("drop_err",    {31'd0, err_o}, 32'd1);
        check("drop_valid",  {31'd0, pe_r_valid_o}, 32'd0);
        check("drop_credit", {29'd0, credit_o}, 32'd4);
        for (int i = 0; i < 3; i++) begin
            step_drive(1, 1, 0, 32'h0, 0, 1);
            check($sformatf("err_sticky%0d", i), {31'd0, err_o}, 32'd1);
        end
        do_reset();
        #1;
        check("err_cleared", {31'd0, err_o}, 32'd0);

        // Response latency with an empty FIFO and a ready PE
        step_drive(1, 1, 0, 32'h0, 0, 1);
        step_drive(0, 0, 1, 32'h55, 0, 1);
        check("lat_same_valid", {31'd0, pe_r_valid_o}, {31'd0, BYP});
        check("lat_same_rdata", pe_r_rdata_o, BYP ? 32'h55 : 32'h0);
        step_drive(0, 0, 0, 32'h0, 0, 1);
        check("lat_next_valid",  {31'd0, pe_r_valid_o}, {31'd0, !BYP});
        check("lat_next_rdata",  pe_r_rdata_o, BYP ? 32'h0 : 32'h55);
        check("lat_next_credit", {29'd0, credit_o}, BYP ? 32'd4 : 32'd3);
        step_drive(0, 0, 0, 32'h0, 0, 1);
        check("lat_done_valid",  {31'd0, pe_r_valid_o}, 32'd0);
        check("lat_done_credit", {29'd0, credit_o}, 32'd4);
        check("lat_done_err",    {31'd0, err_o}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
